// File: rtl/scope_stream_pkg.sv
// ---------------------------------------------------------------------------
// scope_stream_pkg
// Definitions shared by the ADC capture streaming blocks:
//   ADC_W / LANE_W : default ADC word width and transmit lane width
//   lanes()        : number of OUT_W lanes contained in an IN_W word
//   ser_state_e    : serializer state encoding (IDLE / SHIFT)
// ---------------------------------------------------------------------------
package scope_stream_pkg;

  localparam int unsigned ADC_W  = 32;
  localparam int unsigned LANE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int unsigned lanes(input int unsigned in_w,
                                        input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
// Takes one IN_W-bit word per valid/ready handshake and emits it as up to
// N = IN_W/OUT_W lanes on a valid/ready output stream. Lane order is set by
// MSB_FIRST. in_cnt selects a short word (beats - 1, clamped to N-1). The
// next word is accepted on the last beat of the current one, so back-to-back
// traffic runs at one beat per clock.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input word handshake
//   in_data  [IN_W]       word to serialize
//   in_cnt   [CW]         beats to emit minus 1
//   out_valid / out_ready output beat handshake
//   out_data [OUT_W]      current lane
//   out_last              final beat of the word
//   busy                  a word is held (same as out_valid)
// ---------------------------------------------------------------------------
module word_serializer
  import scope_stream_pkg::*;
#(
  parameter  int unsigned IN_W      = ADC_W,
  parameter  int unsigned OUT_W     = LANE_W,
  parameter  bit          MSB_FIRST = 1'b1,
  localparam int unsigned N         = lanes(IN_W, OUT_W),
  localparam int unsigned CW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CW-1:0]    in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  if (((IN_W % OUT_W) != 0) || (N < 2)) begin : g_param_check
    $fatal(1, "word_serializer: IN_W must be a multiple of OUT_W with N >= 2");
  end

  // Lane presented on out_data; the register shifts toward this end.
  localparam int unsigned LANE_LO = MSB_FIRST ? (IN_W - OUT_W) : 0;
  localparam logic [CW-1:0] MAX_REM = CW'(N - 1);

  ser_state_e      r_state;
  logic [IN_W-1:0] r_sreg;
  logic [CW-1:0]   r_rem;

  ser_state_e      w_state_n;
  logic [IN_W-1:0] w_sreg_n;
  logic [CW-1:0]   w_rem_n;
  logic [CW-1:0]   w_cnt_clamped;
  logic [IN_W-1:0] w_sreg_shifted;
  logic            w_out_valid;
  logic            w_out_last;
  logic            w_out_fire;
  logic            w_in_ready;
  logic            w_in_fire;

  always_comb begin
    w_out_valid    = (r_state == SHIFT);
    w_out_last     = w_out_valid & (r_rem == '0);
    w_out_fire     = w_out_valid & out_ready;
    // Combinational from out_ready: a word is taken on the final beat.
    w_in_ready     = (r_state == IDLE) | (w_out_fire & w_out_last);
    w_in_fire      = in_valid & w_in_ready;
    w_cnt_clamped  = (in_cnt > MAX_REM) ? MAX_REM : in_cnt;
    w_sreg_shifted = MSB_FIRST ? (r_sreg << OUT_W) : (r_sreg >> OUT_W);
  end

  always_comb begin
    w_state_n = r_state;
    w_sreg_n  = r_sreg;
    w_rem_n   = r_rem;
    unique case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_sreg_n  = in_data;
          w_rem_n   = w_cnt_clamped;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_fire) begin
          if (r_rem != '0) begin
            w_sreg_n = w_sreg_shifted;
            w_rem_n  = r_rem - CW'(1);
          end else if (w_in_fire) begin
            w_sreg_n = in_data;
            w_rem_n  = w_cnt_clamped;
          end else begin
            w_sreg_n  = w_sreg_shifted;
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sreg  <= w_sreg_n;
      r_rem   <= w_rem_n;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_last  = w_out_last;
  assign busy      = w_out_valid;
  assign out_data  = r_sreg[LANE_LO +: OUT_W];

endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised word-to-lane serializer for the ADC capture path: it accepts one `IN_W`-bit word per valid/ready handshake and emits it as `IN_W/OUT_W` narrower beats on a valid/ready output stream. It supports selectable lane order and short (partial) words, and it reaches zero-bubble throughput by accepting the next word on the last beat of the current one. It sits between the ADC word register and the byte-wide transmit/storage logic.

## Interface
- `IN_W`, 32, input word width; must be an integer multiple of `OUT_W`.
- `OUT_W`, 8, output lane width.
- `MSB_FIRST`, 1, 1 = most-significant lane first, 0 = least-significant lane first.
- Derived: `N = IN_W/OUT_W` (N ≥ 2), `CW = $clog2(N)`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can take a word this cycle.
- `in_data`  in  IN_W  word to serialize.
- `in_cnt`  in  CW  number of beats to emit, minus 1; values ≥ N are treated as N−1.
- `out_valid`  out  1  `out_data` holds a beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  OUT_W  current lane.
- `out_last`  out  1  current beat is the final beat of its word.
- `busy`  out  1  a word is held (equals `out_valid`).

## Operation
- Two states:
  - IDLE: no word held.
  - SHIFT: word held in the shift register, with beat counter `rem` holding the remaining beats minus 1.
- Input handshake: `in_fire = in_valid & in_ready`. Output handshake: `out_fire = out_valid & out_ready`.
- `in_ready = (state==IDLE) | (out_fire & out_last)`. This is combinational from `out_ready`; it gives the zero-bubble handoff.
- IDLE, on `in_fire`:
  - Load the shift register with `in_data`.
  - Set `rem = min(in_cnt, N−1)`.
  - Go to SHIFT.
- SHIFT, on `out_fire` with `rem ≠ 0`:
  - Shift by `OUT_W` (left when `MSB_FIRST`, right otherwise).
  - Decrement `rem`.
- SHIFT, on `out_fire` with `rem == 0`:
  - If `in_fire` in the same cycle, load the new word and stay in SHIFT.
  - Otherwise go to IDLE.
- Lane selection:
  - `out_data` = top `OUT_W` bits of the shift register if `MSB_FIRST`, else the bottom `OUT_W` bits.
  - A partial word of k beats emits lanes N−1…N−k when `MSB_FIRST`, and 0…k−1 otherwise.
- `out_last = out_valid & (rem == 0)`.
- While `out_valid` is high and `out_ready` is low: `out_data`, `out_last` and `rem` hold stable.
- Vacated shift-register bits fill with zero.
- `in_valid` while SHIFT and not on the last fired beat: not accepted (`in_ready` = 0); upstream must hold its data.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0, `rem` = 0, shift register = 0, state IDLE. `in_ready` is 1 in the cycle after reset deasserts.
- Latency: a word accepted at edge t is presented as its first beat in the cycle after t (`out_valid` high after edge t).
- Sustained rate: with `out_ready` held high and back-to-back input, exactly one beat per clock and no idle cycle between words.
- A 1-beat word (`in_cnt` = 0) can be accepted every cycle.
- `rst` asserted mid-word: the held word is discarded, with no further beats. On the next edge all state returns to reset values, and any `in_valid` that cycle is ignored.
- `rst` has priority over all handshakes in the same cycle.

## Structure
- Shared package `scope_stream_pkg`:
  - lane-count function `lanes(IN_W, OUT_W)`.
  - state enum (IDLE/SHIFT).
  - default widths `ADC_W` = 32 and `LANE_W` = 8.
- Elaboration check: `IN_W % OUT_W == 0` and `N ≥ 2`; otherwise fatal.
- Single module; a sub-module is not needed. Lane extraction is one indexed slice of the shift register.

## Test plan
- Full word, MSB first: reset, then `in_data` = 0xA1B2C3D4, `in_cnt` = 3, `out_ready` = 1 → beats A1, B2, C3, D4 on 4 consecutive cycles; `out_last` only on D4; `busy` low afterward.
- LSB first (`MSB_FIRST` = 0), same word → beats D4, C3, B2, A1; `out_last` on A1.
- Back-to-back: 0x11223344 then 0x55667788 with `in_valid` held → 8 beats 11..88 in 8 consecutive cycles; second word accepted on the cycle of beat 44.
- Backpressure: drop `out_ready` for 3 cycles after beat B2 → B2 held stable with `out_valid` = 1 and `in_ready` = 0; sequence resumes C3, D4 unchanged.
- Partial and clamped words:
  - `in_cnt` = 1 on 0xCAFEBABE → beats CA, FE with `out_last` on FE.
  - With `IN_W` = 24, `OUT_W` = 8, `in_cnt` = 3 → clamped to 3 beats.
- Reset mid-word: assert `rst` after beat B2 → next cycle `out_valid` = 0 and `out_data` = 0; a subsequent 0x01020304 emits 01, 02, 03, 04 with no residue.
